ft601q_245_chip_emu: RTL and testbench
======================================

# ft601q_245_chip_emu

Synthesizable device-side emulator of the FT601Q in 245 synchronous FIFO mode, 32-bit bus. It sits on the chip end of the FT601 bus, opposite the FPGA-side 245 wrapper. Words written by the wrapper are stored in an internal loopback FIFO and offered back to the wrapper for reading. Used for on-board self-test without a USB host, and as a cycle-accurate simulation partner. The bus is split into in/out/oe signals; a board top assembles the inout pins.

## Interface
- DEPTH_AW, 10: loopback FIFO address width; DEPTH = 2**DEPTH_AW words of 32 data bits + 4 BE bits.
- PRELOAD, 16: words pushed after reset (data 0,1,2,…; BE 4'hF). Must be ≤ DEPTH.

- sys_clk_i  in  1  bus clock (drives the wrapper's USB3_DCLK); one clock domain.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- ftdi_rxf_n  out  1  low = FIFO holds readable data.
- ftdi_txe_n  out  1  low = FIFO can accept a word.
- ftdi_oe_n  in  1  low = FPGA releases the bus; emulator drives it.
- ftdi_rd_n  in  1  low = read strobe.
- ftdi_wr_n  in  1  low = write strobe.
- ftdi_data_i  in  32  bus data from the FPGA.
- ftdi_be_i  in  4  byte enables from the FPGA (active-high).
- ftdi_data_o  out  32  bus data to the FPGA.
- ftdi_be_o  out  4  byte enables to the FPGA.
- ftdi_bus_oe  out  1  high = emulator drives data/BE; equals ~ftdi_oe_n, registered.
- wr_word_cnt  out  32  accepted writes, wraps at 2^32.
- rd_word_cnt  out  32  accepted reads, wraps at 2^32.
- ovf_err  out  1  sticky: write strobe seen while ftdi_txe_n high.
- bus_err  out  1  sticky: ftdi_wr_n low while ftdi_oe_n low.

## Operation
- State machine:
  - PRELOAD → IDLE after PRELOAD pushes. With PRELOAD=0, leaves PRELOAD on the first cycle after reset release.
  - IDLE → RD when ftdi_oe_n = 0.
  - IDLE → WR when ftdi_wr_n = 0 and ftdi_oe_n = 1.
  - RD → IDLE when ftdi_oe_n = 1.
  - WR → IDLE when ftdi_wr_n = 1.
- In PRELOAD: ftdi_rxf_n = 1, ftdi_txe_n = 1, and all strobes are ignored.
- Write accept: edge with ftdi_wr_n=0, ftdi_txe_n=0, ftdi_oe_n=1, state ≠ PRELOAD. Pushes {be_i, data_i} and increments wr_word_cnt.
  - A write with ftdi_oe_n=0 is dropped and sets bus_err.
  - A write with ftdi_txe_n=1 is dropped and sets ovf_err.
- Read accept: edge with ftdi_oe_n=0, ftdi_rd_n=0, ftdi_rxf_n=0. Pops the head and increments rd_word_cnt.
  - A read with ftdi_rxf_n=1 has no effect.
  - ftdi_rd_n=0 with ftdi_oe_n=1 is ignored.
- Reads and writes are mutually exclusive by construction, so count changes by at most 1 per cycle.
- Flags are registered from next-state count:
  - ftdi_rxf_n ← (count_next == 0)
  - ftdi_txe_n ← (count_next == DEPTH)
  - No skid is needed: every accepted write fits, and every accepted read has data.
- Pointers are DEPTH_AW bits and wrap naturally. count is DEPTH_AW+1 bits and spans 0..DEPTH.
- Reset values:
  - ftdi_rxf_n=1, ftdi_txe_n=1, ftdi_bus_oe=0
  - ftdi_data_o=0, ftdi_be_o=0
  - counters=0, errors=0
  - FIFO empty, state PRELOAD
- Reset asserted mid-burst: everything returns to reset values immediately. The FIFO contents are discarded and PRELOAD reruns.

## Timing
- All outputs are registered on the rising edge of sys_clk_i.
- ftdi_bus_oe rises 1 cycle after ftdi_oe_n falls and drops 1 cycle after it rises (bus turnaround).
- Read data path:
  - ftdi_data_o/ftdi_be_o always show the current head. They are registered from mem[rd_ptr_next], so after a pop the next word appears on the following edge.
  - Back-to-back reads stream 1 word/cycle.
  - The first word is valid 1 cycle after ftdi_oe_n falls. The FPGA asserts ftdi_rd_n no earlier than that.
- ftdi_rxf_n goes high the cycle after the last word is popped.
- ftdi_txe_n goes high the cycle after the DEPTH-th word is written. It goes low the cycle after the first pop from full.
- A write-to-read turnaround makes the written word readable: ftdi_rxf_n falls 1 cycle after the write edge into an empty FIFO.

## Test plan
- Reset, PRELOAD=16 → ftdi_rxf_n falls at cycle 17 after rst_n_i release; ftdi_txe_n low; wrapper loopback reads 0..15 in order with BE=4'hF; rd_word_cnt=16.
- Full loopback with the FPGA wrapper and PRELOAD=16, running 10 000 cycles → wr_word_cnt and rd_word_cnt both increase; the read stream is 0..15 repeating; ovf_err=0, bus_err=0.
- Fill to full with DEPTH_AW=4 and PRELOAD=0: write 16 words 0xA0..0xAF → ftdi_txe_n=1 on the cycle after the 16th write. A 17th strobe is dropped and sets ovf_err=1. One read returns 0xA0, and ftdi_txe_n=0 on the next cycle.
- Drive ftdi_wr_n=0 while ftdi_oe_n=0 → no push, bus_err=1, wr_word_cnt unchanged.
- Write BE=4'b0011, data 0x12345678; then read → ftdi_be_o=4'b0011, ftdi_data_o=0x12345678.
- Assert rst_n_i low mid-read-burst → all outputs return to reset values within the same cycle and the FIFO is emptied; after release, PRELOAD data restarts from 0.

Source files
------------

// File: rtl/ft601q_245_chip_emu.sv
// Device-side FT601Q 245 synchronous FIFO emulator: words written by the FPGA
// are looped back through an internal FIFO and offered for reading.
module ft601q_245_chip_emu #(
    parameter int DEPTH_AW = 10,
    parameter int PRELOAD  = 16
) (
    input  logic        sys_clk_i,
    input  logic        rst_n_i,
    output logic        ftdi_rxf_n,
    output logic        ftdi_txe_n,
    input  logic        ftdi_oe_n,
    input  logic        ftdi_rd_n,
    input  logic        ftdi_wr_n,
    input  logic [31:0] ftdi_data_i,
    input  logic [3:0]  ftdi_be_i,
    output logic [31:0] ftdi_data_o,
    output logic [3:0]  ftdi_be_o,
    output logic        ftdi_bus_oe,
    output logic [31:0] wr_word_cnt,
    output logic [31:0] rd_word_cnt,
    output logic        ovf_err,
    output logic        bus_err
);
    // state      | meaning
    // ST_PRELOAD | pushing the 0,1,2,... self-test pattern; bus ignored
    // ST_IDLE    | waiting for the FPGA to own a read or write cycle
    // ST_RD      | FPGA released the bus (oe_n low); emulator drives data
    // ST_WR      | FPGA is strobing writes
    localparam int DEPTH = 2 ** DEPTH_AW;
    localparam logic [DEPTH_AW:0] DEPTH_C  = (DEPTH_AW + 1)'(DEPTH);
    localparam logic [DEPTH_AW:0] PRE_LAST = (PRELOAD == 0) ? '0 : (DEPTH_AW + 1)'(PRELOAD - 1);

    typedef enum logic [1:0] {ST_PRELOAD, ST_IDLE, ST_RD, ST_WR} state_t;

    state_t              state_q, state_d;
    logic [35:0]         mem_q [DEPTH];
    logic [DEPTH_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_AW:0]   count_q, count_d;
    logic [DEPTH_AW:0]   pre_cnt_q, pre_cnt_d;
    logic                rxf_n_q, rxf_n_d;
    logic                txe_n_q, txe_n_d;
    logic                bus_oe_q;
    logic [35:0]         head_q, head_d;
    logic [31:0]         wr_cnt_q, wr_cnt_d;
    logic [31:0]         rd_cnt_q, rd_cnt_d;
    logic                ovf_q, ovf_d;
    logic                berr_q, berr_d;
    logic                active;
    logic                wr_acc;
    logic                rd_acc;
    logic                push;
    logic                pop;
    logic [35:0]         wdata;

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        push      = 1'b0;
        wdata     = {ftdi_be_i, ftdi_data_i};
        ovf_d     = ovf_q;
        berr_d    = berr_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;

        active = (state_q != ST_PRELOAD);
        wr_acc = active && !ftdi_wr_n && !txe_n_q && ftdi_oe_n;
        rd_acc = !ftdi_oe_n && !ftdi_rd_n && !rxf_n_q;
        pop    = rd_acc;

        case (state_q)
            ST_PRELOAD: begin
                if (PRELOAD != 0) begin
                    push      = 1'b1;
                    wdata     = {4'hF, 32'(pre_cnt_q)};
                    pre_cnt_d = pre_cnt_q + 1'b1;
                end
                if ((PRELOAD == 0) || (pre_cnt_q == PRE_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!ftdi_oe_n) begin
                    state_d = ST_RD;
                end else if (!ftdi_wr_n) begin
                    state_d = ST_WR;
                end
            end
            ST_RD: begin
                if (ftdi_oe_n) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (ftdi_wr_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_PRELOAD;
        endcase

        if (wr_acc) begin
            push     = 1'b1;
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
        if (rd_acc) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (active && !ftdi_wr_n && !ftdi_oe_n) begin
            berr_d = 1'b1;
        end
        if (active && !ftdi_wr_n && txe_n_q) begin
            ovf_d = 1'b1;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // A push into an empty FIFO lands exactly at the new head; forward it.
        head_d = (push && (wr_ptr_q == rd_ptr_d)) ? wdata : mem_q[rd_ptr_d];

        rxf_n_d = (state_q == ST_PRELOAD) ? 1'b1 : (count_d == '0);
        txe_n_d = (state_q == ST_PRELOAD) ? 1'b1 : (count_d == DEPTH_C);
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_PRELOAD;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pre_cnt_q <= '0;
            rxf_n_q   <= 1'b1;
            txe_n_q   <= 1'b1;
            bus_oe_q  <= 1'b0;
            head_q    <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            ovf_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pre_cnt_q <= pre_cnt_d;
            rxf_n_q   <= rxf_n_d;
            txe_n_q   <= txe_n_d;
            bus_oe_q  <= ~ftdi_oe_n;
            head_q    <= head_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            ovf_q     <= ovf_d;
            berr_q    <= berr_d;
        end
    end

    // Storage is not reset; emptiness is tracked by the pointers and count.
    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign ftdi_rxf_n  = rxf_n_q;
    assign ftdi_txe_n  = txe_n_q;
    assign ftdi_bus_oe = bus_oe_q;
    assign ftdi_data_o = head_q[31:0];
    assign ftdi_be_o   = head_q[35:32];
    assign wr_word_cnt = wr_cnt_q;
    assign rd_word_cnt = rd_cnt_q;
    assign ovf_err     = ovf_q;
    assign bus_err     = berr_q;

endmodule

// File: tb/tb_ft601q_245_chip_emu.sv
// Loopback emulator bench: directed sequences plus random bus traffic, all
// compared every cycle against a queue-based model of the FIFO behaviour.
module tb_ft601q_245_chip_emu;
    localparam int AW    = 4;
    localparam int PRE   = 6;
    localparam int DEPTH = 2 ** AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        oe_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [31:0] din = '0;
    logic [3:0]  bein = '0;
    logic        rxf_n, txe_n, boe, ovf, berr;
    logic [31:0] dout, wcnt, rcnt;
    logic [3:0]  beout;

    int n_vec = 0;
    int n_err = 0;

    logic [35:0] q[$];
    int          pre_idx;
    bit          pre_m, rxf_m, txe_m, boe_m, ovf_m, berr_m;
    logic [31:0] wcnt_m, rcnt_m;

    always #5 clk = ~clk;

    ft601q_245_chip_emu #(.DEPTH_AW(AW), .PRELOAD(PRE)) u_dut (
        .sys_clk_i   (clk),
        .rst_n_i     (rst_n),
        .ftdi_rxf_n  (rxf_n),
        .ftdi_txe_n  (txe_n),
        .ftdi_oe_n   (oe_n),
        .ftdi_rd_n   (rd_n),
        .ftdi_wr_n   (wr_n),
        .ftdi_data_i (din),
        .ftdi_be_i   (bein),
        .ftdi_data_o (dout),
        .ftdi_be_o   (beout),
        .ftdi_bus_oe (boe),
        .wr_word_cnt (wcnt),
        .rd_word_cnt (rcnt),
        .ovf_err     (ovf),
        .bus_err     (berr)
    );

    task automatic check_eq(input string tag, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pre_idx = 0;
        pre_m   = 1'b1;
        rxf_m   = 1'b1;
        txe_m   = 1'b1;
        boe_m   = 1'b0;
        ovf_m   = 1'b0;
        berr_m  = 1'b0;
        wcnt_m  = '0;
        rcnt_m  = '0;
    endtask

    task automatic model_edge();
        bit wa, ra;
        boe_m = !oe_n;
        if (pre_m) begin
            if (PRE > 0) begin
                q.push_back({4'hF, 32'(pre_idx)});
                pre_idx++;
            end
            if (pre_idx >= PRE) pre_m = 1'b0;
            rxf_m = 1'b1;
            txe_m = 1'b1;
        end else begin
            wa = !wr_n && !txe_m && oe_n;
            ra = !oe_n && !rd_n && !rxf_m;
            if (!wr_n && !oe_n) berr_m = 1'b1;
            if (!wr_n && txe_m) ovf_m = 1'b1;
            if (wa) begin
                q.push_back({bein, din});
                wcnt_m++;
            end
            if (ra) begin
                void'(q.pop_front());
                rcnt_m++;
            end
            rxf_m = (q.size() == 0);
            txe_m = (q.size() == DEPTH);
        end
    endtask

    task automatic check_all();
        check_eq("rxf_n", 36'(rxf_n), 36'(rxf_m));
        check_eq("txe_n", 36'(txe_n), 36'(txe_m));
        check_eq("bus_oe", 36'(boe), 36'(boe_m));
        check_eq("wr_cnt", 36'(wcnt), 36'(wcnt_m));
        check_eq("rd_cnt", 36'(rcnt), 36'(rcnt_m));
        check_eq("ovf_err", 36'(ovf), 36'(ovf_m));
        check_eq("bus_err", 36'(berr), 36'(berr_m));
        if (q.size() > 0) check_eq("head", {beout, dout}, q[0]);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_rxf"}, 36'(rxf_n), 36'd1);
        check_eq({tag, "_txe"}, 36'(txe_n), 36'd1);
        check_eq({tag, "_boe"}, 36'(boe), 36'd0);
        check_eq({tag, "_data"}, {beout, dout}, 36'd0);
        check_eq({tag, "_cnts"}, 36'(wcnt | rcnt), 36'd0);
        check_eq({tag, "_errs"}, 36'({ovf, berr}), 36'd0);
    endtask

    task automatic cycle(input logic o, input logic r, input logic w,
                         input logic [31:0] d, input logic [3:0] b);
        oe_n = o;
        rd_n = r;
        wr_n = w;
        din  = d;
        bein = b;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic        ro;
        logic [31:0] wsave;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        model_reset();
        rst_n = 1'b1;

        // Preload, with a stray write strobe that must be ignored
        for (int i = 0; i < PRE + 2; i++) cycle(1, 1, (i == 2) ? 1'b0 : 1'b1, 32'hDEAD, 4'hF);
        check_eq("pre_rxf_low", 36'(rxf_n), 36'd0);
        check_eq("pre_txe_low", 36'(txe_n), 36'd0);

        cycle(0, 1, 1, 0, 0);
        check_eq("pre_head0", {beout, dout}, {4'hF, 32'd0});
        for (int i = 0; i < PRE; i++) cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        check_eq("pre_rdcnt", 36'(rcnt), 36'(PRE));

        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 0, 32'hA0 + 32'(i), 4'hF);
        check_eq("full_txe", 36'(txe_n), 36'd1);
        cycle(1, 1, 0, 32'hBEEF, 4'hF);
        check_eq("full_ovf", 36'(ovf), 36'd1);
        check_eq("full_wcnt", 36'(wcnt), 36'(DEPTH));
        cycle(1, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        check_eq("full_head", 36'(dout), 36'hA0);
        cycle(0, 0, 1, 0, 0);
        check_eq("unfull_txe", 36'(txe_n), 36'd0);
        for (int i = 1; i < DEPTH; i++) cycle(0, 0, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        check_eq("drain_rxf", 36'(rxf_n), 36'd1);

        cycle(1, 1, 0, 32'h12345678, 4'b0011);
        check_eq("turn_rxf", 36'(rxf_n), 36'd0);
        cycle(0, 1, 1, 0, 0);
        check_eq("be_word", {beout, dout}, {4'b0011, 32'h12345678});
        cycle(0, 0, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);

        check_eq("berr_before", 36'(berr), 36'd0);
        wsave = wcnt_m;
        cycle(0, 1, 0, 32'h5555, 4'hF);
        check_eq("berr_set", 36'(berr), 36'd1);
        check_eq("berr_wcnt", 36'(wcnt), 36'(wsave));
        cycle(1, 1, 1, 0, 0);

        ro = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) ro = ~ro;
            cycle(ro, ($urandom_range(0, 2) == 0), 1'(ro ? $urandom_range(0, 1) : 1), $urandom, 4'($urandom));
        end

        cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 32'hC0 + 32'(i), 4'hF);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        oe_n = 1'b1;
        rd_n = 1'b1;
        wr_n = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < PRE + 1; i++) cycle(1, 1, 1, 0, 0);
        check_eq("rerun_rxf", 36'(rxf_n), 36'd0);
        check_eq("rerun_head", 36'(dout), 36'd0);
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < PRE; i++) cycle(0, 0, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        check_eq("rerun_rdcnt", 36'(rcnt), 36'(PRE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
